// File: rtl/baud_ctrl.sv
// baud_ctrl: owns the baud_gen divisor/enable, sequences safe divisor updates, and turns OSR ticks into bit/mid strobes.
// Optional macro BAUD_CTRL_BUSY_HOLD_EN: while tx/rx is mid-frame (busy_i), hold off divisor updates and run_i deassert.
module baud_ctrl #(
  parameter int DIV_W = 8,
  parameter int OSR   = 16,
  parameter int OSR_W = $clog2(OSR)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  input  logic             run_i,
  input  logic             busy_i,
  input  logic             osr_tick_i,
  output logic             bg_en_o,
  output logic [DIV_W-1:0] bg_div_o,
  output logic             bit_tick_o,
  output logic             mid_tick_o,
  output logic             active_o
);

  typedef enum logic [1:0] {IDLE, RUN, UPDATE0, UPDATE1} state_t;

`ifdef BAUD_CTRL_BUSY_HOLD_EN
  localparam bit BUSY_HOLD = 1'b1;
`else
  localparam bit BUSY_HOLD = 1'b0;
`endif

  localparam logic [OSR_W-1:0] CNT_LAST = OSR_W'(OSR - 1);
  localparam logic [OSR_W-1:0] CNT_MID  = OSR_W'(OSR / 2 - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OSR_W-1:0] cnt_q, cnt_d;
  logic             en_q;
  logic             bit_q, bit_d;
  logic             mid_q, mid_d;
  logic             err_q, err_d;
  logic             hold;
  logic             ready;
  logic             accept;
  logic             counting;

  assign hold  = BUSY_HOLD & busy_i;
  assign ready = (state_q == IDLE) | ((state_q == RUN) & ~hold);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    err_d    = 1'b0;
    cnt_d    = '0;
    bit_d    = 1'b0;
    mid_d    = 1'b0;
    accept   = cfg_valid_i & ready;
    counting = 1'b0;

    if (accept && cfg_div_i == '0) begin
      // a zero divisor is consumed but never reaches baud_gen
      err_d = 1'b1;
    end else if (accept) begin
      div_d   = cfg_div_i;
      state_d = UPDATE0;
    end else begin
      case (state_q)
        IDLE:    if (run_i && div_q != '0) state_d = RUN;
        RUN:     if (!run_i && !hold) state_d = IDLE;
        UPDATE0: state_d = UPDATE1;
        UPDATE1: state_d = run_i ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end

    // ticks only count in cycles that start and stay in RUN; any exit restarts the bit
    counting = (state_q == RUN) && (state_d == RUN);
    if (counting) begin
      cnt_d = cnt_q;
      if (osr_tick_i) begin
        mid_d = (cnt_q == CNT_MID);
        bit_d = (cnt_q == CNT_LAST);
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + OSR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      bit_q   <= 1'b0;
      mid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == RUN);
      bit_q   <= bit_d;
      mid_q   <= mid_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready_o = ready;
  assign cfg_err_o   = err_q;
  assign bg_en_o     = en_q;
  assign active_o    = en_q;
  assign bg_div_o    = div_q;
  assign bit_tick_o  = bit_q;
  assign mid_tick_o  = mid_q;

endmodule
